// File: rtl/axi_arbiter_wr.sv
// Purpose : round-robin write-path arbiter; one owner holds AW/W/B from AW request to B handshake.
// Latency : grant registered, visible 1 cycle after a request in IDLE; dropped 1 cycle after B.
// Backpr. : non-owner requests are left pending; the owner's handshakes are only observed.
// Ports   : ACLK/ARESET (sync, active-high); m_AWVALID request lines; s_AWREADY, s_WVALID,
//           s_WREADY, s_WLAST, s_BVALID, m_BREADY muxed handshake signals; m_wgrnt one-hot grant;
//           grnt_id owner index; busy; beat_cnt W beats this burst; err_overrun sticky overrun flag.
module axi_arbiter_wr #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_BEATS   = 256
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [NUM_MASTERS-1:0]         m_AWVALID,
  input  logic                           s_AWREADY,
  input  logic                           s_WVALID,
  input  logic                           s_WREADY,
  input  logic                           s_WLAST,
  input  logic                           s_BVALID,
  input  logic                           m_BREADY,
  output logic [NUM_MASTERS-1:0]         m_wgrnt,
  output logic [$clog2(NUM_MASTERS)-1:0] grnt_id,
  output logic                           busy,
  output logic [8:0]                     beat_cnt,
  output logic                           err_overrun
);

  localparam int         ID_W    = $clog2(NUM_MASTERS);
  localparam logic [8:0] MAX_CNT = 9'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] wgrnt_q, wgrnt_d;
  logic [ID_W-1:0]        gid_q, gid_d;
  logic [ID_W-1:0]        last_owner_q, last_owner_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [8:0]             beat_q, beat_d;
  logic                   err_q, err_d;

  logic                   pick_vld;
  logic [ID_W-1:0]        pick_id;
  logic [ID_W-1:0]        cand;
  logic                   w_hs;
  logic                   aw_now;
  logic                   wl_now;

  always_comb begin
    state_d      = state_q;
    wgrnt_d      = wgrnt_q;
    gid_d        = gid_q;
    last_owner_d = last_owner_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    beat_d       = beat_q;
    err_d        = err_q;
    pick_vld     = 1'b0;
    pick_id      = '0;
    cand         = '0;

    // Round-robin search starting just after the last owner; the first hit wins.
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = ID_W'((int'(last_owner_q) + i) % NUM_MASTERS);
      if (!pick_vld && m_AWVALID[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end

    w_hs   = s_WVALID & s_WREADY;
    // "Already done or completing this cycle" so AW and WLAST in the same cycle both count.
    aw_now = aw_done_q | (s_AWREADY & m_AWVALID[gid_q]);
    wl_now = w_done_q | (w_hs & s_WLAST);

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d          = XFER;
          wgrnt_d          = '0;
          wgrnt_d[pick_id] = 1'b1;
          gid_d            = pick_id;
          aw_done_d        = 1'b0;
          w_done_d         = 1'b0;
          beat_d           = '0;
        end
      end
      XFER: begin
        aw_done_d = aw_now;
        w_done_d  = wl_now;
        if (w_hs) begin
          if (beat_q != MAX_CNT) begin
            beat_d = beat_q + 9'd1;
          end
          // Overrun only flags the beat that lands exactly on the limit without WLAST;
          // the transaction still runs to WLAST and B.
          if ((beat_q == MAX_CNT - 9'd1) && !s_WLAST) begin
            err_d = 1'b1;
          end
        end
        if (aw_now && wl_now) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (s_BVALID && m_BREADY) begin
          state_d      = IDLE;
          wgrnt_d      = '0;
          last_owner_d = gid_q;
        end
      end
      default: begin
        state_d = IDLE;
        wgrnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      wgrnt_q      <= '0;
      gid_q        <= '0;
      last_owner_q <= ID_W'(NUM_MASTERS - 1);
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      beat_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wgrnt_q      <= wgrnt_d;
      gid_q        <= gid_d;
      last_owner_q <= last_owner_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
    end
  end

  assign m_wgrnt     = wgrnt_q;
  assign grnt_id     = gid_q;
  assign busy        = (state_q != IDLE);
  assign beat_cnt    = beat_q;
  assign err_overrun = err_q;

endmodule
